// File: rtl/tc_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tc_timer_ctrl
//
// Timer controller that sits in front of a loadable up-counter (the counter
// loads cnt_in when cnt_save=1, otherwise increments by one). By holding,
// reloading or releasing the counter it turns it into a programmable periodic
// or one-shot timer and reports tick/done/running status.
//
// Period length is ((period - reload) mod 2^SIZE) + 1 counting cycles.
//
// Optional feature: define TC_TIMER_PRESCALE_EN to add cfg_prescale and an
// 8-bit prescaler. The counter then advances only once every
// (cfg_prescale + 1) RUN cycles. start/stop still act on any cycle.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cfg_we        write cfg_period/cfg_reload/cfg_mode (and cfg_prescale)
//   cfg_period    counter value that ends a period
//   cfg_reload    value loaded into the counter at start / period end
//   cfg_mode      0 periodic, 1 one-shot
//   cfg_prescale  (TC_TIMER_PRESCALE_EN only) advance divider minus one
//   start, stop   level-sampled start/restart and stop requests (stop wins)
//   cnt_value     counter output
//   cnt_save      counter load enable
//   cnt_in        counter load value
//   tick          1-cycle pulse in the cycle after a period match
//   done          high while the one-shot timer has expired
//   running       high while the timer is counting
// -----------------------------------------------------------------------------
module tc_timer_ctrl #(
  parameter int SIZE                 = 8,
  parameter bit MODE_ONESHOT_DEFAULT = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [SIZE-1:0] cfg_period,
  input  logic [SIZE-1:0] cfg_reload,
  input  logic            cfg_mode,
`ifdef TC_TIMER_PRESCALE_EN
  input  logic [7:0]      cfg_prescale,
`endif
  input  logic            start,
  input  logic            stop,
  input  logic [SIZE-1:0] cnt_value,
  output logic            cnt_save,
  output logic [SIZE-1:0] cnt_in,
  output logic            tick,
  output logic            done,
  output logic            running
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [SIZE-1:0] r_period;
  logic [SIZE-1:0] r_reload;
  logic            r_mode;
  logic            r_tick;
  logic            w_tick_next;
  logic            w_advance;

  // ---------------------------------------------------------------------------
  // Configuration registers: writable in any state, used from the next cycle.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; combinational logic below uses blocking (=).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_period <= '1;
      r_reload <= '0;
      r_mode   <= MODE_ONESHOT_DEFAULT;
    end else if (cfg_we) begin
      r_period <= cfg_period;
      r_reload <= cfg_reload;
      r_mode   <= cfg_mode;
    end
  end

  // ---------------------------------------------------------------------------
  // Prescaler: an advance cycle happens when the count reaches cfg_prescale.
  // Any start/stop, every advance (which covers reloads) and leaving RUN clear
  // the count, so each period starts with a full prescale interval.
  // ---------------------------------------------------------------------------
`ifdef TC_TIMER_PRESCALE_EN
  logic [7:0] r_presc_cfg;
  logic [7:0] r_presc_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cfg <= '0;
    end else if (cfg_we) begin
      r_presc_cfg <= cfg_prescale;
    end
  end

  assign w_advance = (r_presc_cnt == r_presc_cfg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc_cnt <= '0;
    end else if (r_state == S_RUN && !start && !stop && !w_advance) begin
      r_presc_cnt <= r_presc_cnt + 8'd1;
    end else begin
      r_presc_cnt <= '0;
    end
  end
`else
  assign w_advance = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // FSM state and registered tick.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_tick  <= w_tick_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and counter control. "Hold" means reloading the counter with
  // its own value, which is the default.
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block is given a default first so that no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    cnt_save    = 1'b1;
    cnt_in      = cnt_value;
    w_next      = r_state;
    w_tick_next = 1'b0;

    case (r_state)
      S_RUN: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (start) begin
          // Restart: reload without reporting a tick.
          cnt_in = r_reload;
        end else if (w_advance) begin
          if (cnt_value == r_period) begin
            w_tick_next = 1'b1;
            if (r_mode) begin
              w_next = S_DONE;
            end else begin
              cnt_in = r_reload;
            end
          end else begin
            cnt_save = 1'b0;
          end
        end
      end
      default: begin
        // IDLE and DONE: hold until a start without a concurrent stop.
        if (start && !stop) begin
          cnt_in = r_reload;
          w_next = S_RUN;
        end
      end
    endcase
  end

  assign tick    = r_tick;
  assign running = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);

endmodule

// File: tb/tb_tc_timer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tc_timer_ctrl
//
// Self-checking bench for tc_timer_ctrl. A behavioural model of the loadable
// up-counter closes the loop. Expected per-cycle values (counter, tick,
// running, done) are computed from the period formula, pushed to a queue when
// stimulus is driven, and popped and compared after each clock edge.
// Define TC_TIMER_PRESCALE_EN for both RTL and bench to exercise the prescaler.
// -----------------------------------------------------------------------------
module tb_tc_timer_ctrl;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we;
  logic [SIZE-1:0] cfg_period;
  logic [SIZE-1:0] cfg_reload;
  logic            cfg_mode;
`ifdef TC_TIMER_PRESCALE_EN
  logic [7:0]      cfg_prescale;
`endif
  logic            start;
  logic            stop;
  logic [SIZE-1:0] cnt_value;
  logic            cnt_save;
  logic [SIZE-1:0] cnt_in;
  logic            tick;
  logic            done;
  logic            running;

  tc_timer_ctrl #(.SIZE(SIZE), .MODE_ONESHOT_DEFAULT(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_we     (cfg_we),
    .cfg_period (cfg_period),
    .cfg_reload (cfg_reload),
    .cfg_mode   (cfg_mode),
`ifdef TC_TIMER_PRESCALE_EN
    .cfg_prescale (cfg_prescale),
`endif
    .start      (start),
    .stop       (stop),
    .cnt_value  (cnt_value),
    .cnt_save   (cnt_save),
    .cnt_in     (cnt_in),
    .tick       (tick),
    .done       (done),
    .running    (running)
  );

  always #5 clk = ~clk;

  // Loadable up-counter being controlled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           cnt_value <= '0;
    else if (cnt_save) cnt_value <= cnt_in;
    else               cnt_value <= cnt_value + 8'd1;
  end

  typedef struct {
    logic [SIZE-1:0] cnt;
    logic            tick;
    logic            running;
    logic            done;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic push(input int cnt, input bit tk, input bit run, input bit dn);
    exp_t e;
    e.cnt     = cnt[SIZE-1:0];
    e.tick    = tk;
    e.running = run;
    e.done    = dn;
    sb.push_back(e);
    last_exp  = e;
  endtask

  // Expected observations for edges 1..n after a start in a fresh run:
  // each counter value lasts p cycles, a period is len values long, and a
  // tick follows every period-closing advance.
  task automatic push_run(input int reload, input int period, input int p, input int n);
    int len;
    len = ((period - reload + 256) % 256) + 1;
    for (int k = 1; k <= n; k++) begin
      push((reload + ((k - 1) / p) % len) % 256,
           (k > 1) && (((k - 1) % (p * len)) == 0), 1'b1, 1'b0);
    end
  endtask

  // Advance n clocks; start/stop act as one-cycle pulses. After each edge,
  // pop one expectation and compare.
  task automatic run_cycles(input string tag, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      stop  = 1'b0;
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL %s: scoreboard empty at cycle %0d", tag, i);
      end else begin
        e = sb.pop_front();
        check({tag, ".cnt"},     32'(cnt_value), 32'(e.cnt));
        check({tag, ".tick"},    32'(tick),      32'(e.tick));
        check({tag, ".running"}, 32'(running),   32'(e.running));
        check({tag, ".done"},    32'(done),      32'(e.done));
      end
    end
  endtask

  task automatic configure(input int period, input int reload, input bit mode, input int presc);
    cfg_period = period[SIZE-1:0];
    cfg_reload = reload[SIZE-1:0];
    cfg_mode   = mode;
`ifdef TC_TIMER_PRESCALE_EN
    cfg_prescale = presc[7:0];
`endif
    cfg_we = 1'b1;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
  endtask

  // Stop from RUN: counter frozen at its current value, state IDLE, no tick.
  task automatic stop_run(input string tag);
    stop = 1'b1;
    push(32'(last_exp.cnt), 1'b0, 1'b0, 1'b0);
    run_cycles(tag, 1);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_period = '0; cfg_reload = '0; cfg_mode = 1'b0;
`ifdef TC_TIMER_PRESCALE_EN
    cfg_prescale = '0;
`endif
    start = 1'b0; stop = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.running", 32'(running), 0);
    check("rst.done",    32'(done),    0);
    check("rst.tick",    32'(tick),    0);
    check("rst.save",    32'(cnt_save), 1);
    check("rst.cnt_in",  32'(cnt_in),  0);
    @(negedge clk);
    rst = 1'b0;

    // Periodic: 2,3,4,5,2,... tick every 4 cycles.
    configure(5, 2, 1'b0, 0);
    start = 1'b1;
    push_run(2, 5, 1, 10);
    run_cycles("periodic", 10);

    // Stop at value 3, then start+stop together in IDLE.
    stop_run("stop");
    push(3, 0, 0, 0); push(3, 0, 0, 0);
    run_cycles("idle_hold", 2);
    start = 1'b1; stop = 1'b1;
    push(3, 0, 0, 0); push(3, 0, 0, 0);
    run_cycles("start_stop_idle", 2);

    // Restart while the counter sits on the match value: reload, no tick.
    start = 1'b1;
    push_run(2, 5, 1, 4);
    run_cycles("pre_restart", 4);
    start = 1'b1;
    push(2, 0, 1, 0); push(3, 0, 1, 0);
    run_cycles("restart", 2);
    stop_run("restart_stop");

    // One-shot: stops at 5, one tick, DONE; new start reloads.
    configure(5, 2, 1'b1, 0);
    start = 1'b1;
    push_run(2, 5, 1, 4);
    push(5, 1, 0, 1);
    push(5, 0, 0, 1); push(5, 0, 0, 1); push(5, 0, 0, 1);
    run_cycles("oneshot", 8);
    start = 1'b1;
    push(2, 0, 1, 0); push(3, 0, 1, 0);
    run_cycles("oneshot_restart", 2);
    stop_run("oneshot_stop");

    // Wrap through all-ones: 250..255,0..3, period 10.
    configure(3, 250, 1'b0, 0);
    start = 1'b1;
    push_run(250, 3, 1, 21);
    run_cycles("wrap", 21);
    stop_run("wrap_stop");

    // reload == period: match every cycle, tick held high.
    configure(7, 7, 1'b0, 0);
    start = 1'b1;
    push_run(7, 7, 1, 5);
    run_cycles("equal", 5);
    stop_run("equal_stop");

`ifdef TC_TIMER_PRESCALE_EN
    // Prescale 2: value changes every 3rd cycle, tick every 9 cycles.
    configure(2, 0, 1'b0, 2);
    start = 1'b1;
    push_run(0, 2, 3, 20);
    run_cycles("prescale", 20);
    stop_run("prescale_stop");
`endif

    // Asynchronous reset mid-RUN at value 4.
    configure(5, 2, 1'b0, 0);
    start = 1'b1;
    push_run(2, 5, 1, 3);
    run_cycles("pre_rst", 3);
    rst = 1'b1;
    #1;
    check("midrst.running", 32'(running),   0);
    check("midrst.tick",    32'(tick),      0);
    check("midrst.cnt",     32'(cnt_value), 0);
    @(negedge clk);
    rst = 1'b0;
    push(0, 0, 0, 0); push(0, 0, 0, 0); push(0, 0, 0, 0);
    run_cycles("post_rst_hold", 3);
    // Config was reset too: reload 0, period all ones.
    start = 1'b1;
    push_run(0, 255, 1, 3);
    run_cycles("post_rst_run", 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
